// File: rtl/sopc_timer.sv
// Memory-mapped prescaled timer with compare match and IRQ; optional watchdog under TIMER_WDOG_EN.
// Latency: bus reads are combinational; writes, counting and flags update on the rising clk edge.
// Backpressure: none; the slave accepts every bus access in the cycle it is presented.
module sopc_timer #(
    parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
    parameter int unsigned PRESCALE_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce,
    input  logic                  we,
    input  logic [31:0]           addr,
    input  logic [3:0]            sel,
    input  logic [31:0]           data_i,
    output logic [31:0]           data_o,
    output logic                  int_o,
    output logic                  wdog_rst_o
);

    localparam logic [2:0] OFF_CTRL    = 3'd0;
    localparam logic [2:0] OFF_COUNT   = 3'd1;
    localparam logic [2:0] OFF_COMPARE = 3'd2;
    localparam logic [2:0] OFF_STATUS  = 3'd3;
    localparam logic [2:0] OFF_PRE     = 3'd4;

    logic                  hit;
    logic [2:0]            off;
    logic                  wr_en;
    logic [31:0]           wmask;
    logic                  unused_addr;

    logic [2:0]            ctrl_q, ctrl_d;
    logic [31:0]           count_q, count_d;
    logic [31:0]           compare_q, compare_d;
    logic                  match_q, match_d;
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
    logic [PRESCALE_W-1:0] pre_cnt_q, pre_cnt_d;

    logic                  en_run;
    logic                  tick;
    logic                  set_match;
    logic [31:0]           rdata;

    assign hit         = (addr[31:8] == BASE_ADDR[31:8]);
    assign off         = addr[4:2];
    assign wr_en       = ce && we && hit && (sel != 4'b0000);
    assign wmask       = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    assign unused_addr = ^{addr[7:5], addr[1:0]};

    always_comb begin
        ctrl_d     = ctrl_q;
        count_d    = count_q;
        compare_d  = compare_q;
        match_d    = match_q;
        prescale_d = prescale_q;
        pre_cnt_d  = pre_cnt_q;
        set_match  = 1'b0;

        if (wr_en && off == OFF_CTRL)
            ctrl_d = (ctrl_q & ~wmask[2:0]) | (data_i[2:0] & wmask[2:0]);
        if (wr_en && off == OFF_COMPARE)
            compare_d = (compare_q & ~wmask) | (data_i & wmask);
        if (wr_en && off == OFF_PRE)
            prescale_d = (prescale_q & ~wmask[PRESCALE_W-1:0])
                       | (data_i[PRESCALE_W-1:0] & wmask[PRESCALE_W-1:0]);

        // Prescaler only runs while EN was set and is not being cleared this edge,
        // so a write that drops EN freezes COUNT and parks pre_cnt at zero.
        en_run = ctrl_q[0] && ctrl_d[0];
        tick   = en_run && (pre_cnt_q == prescale_q);
        if (!en_run || tick)
            pre_cnt_d = '0;
        else
            pre_cnt_d = pre_cnt_q + PRESCALE_W'(1);

        if (wr_en && off == OFF_COUNT) begin
            count_d = (count_q & ~wmask) | (data_i & wmask);
        end else if (tick) begin
            set_match = (count_q == compare_q);
            count_d   = (set_match && ctrl_q[1]) ? 32'd0 : count_q + 32'd1;
        end

        if (wr_en && off == OFF_STATUS && sel[0] && data_i[0])
            match_d = 1'b0;
        if (set_match)
            match_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q     <= '0;
            count_q    <= '0;
            compare_q  <= '0;
            match_q    <= 1'b0;
            prescale_q <= '0;
            pre_cnt_q  <= '0;
        end else begin
            ctrl_q     <= ctrl_d;
            count_q    <= count_d;
            compare_q  <= compare_d;
            match_q    <= match_d;
            prescale_q <= prescale_d;
            pre_cnt_q  <= pre_cnt_d;
        end
    end

    assign int_o = match_q && ctrl_q[2];

`ifdef TIMER_WDOG_EN
    localparam logic [2:0] OFF_WDOG = 3'd5;

    logic        wr_wdog;
    logic [31:0] wdog_q, wdog_d;
    logic [23:0] wd_cnt_q, wd_cnt_d;

    assign wr_wdog = wr_en && (off == OFF_WDOG);

    // Any write to WDOG is a kick: the down-counter restarts from the new load value.
    always_comb begin
        wdog_d   = wdog_q;
        wd_cnt_d = wd_cnt_q;
        if (wr_wdog) begin
            wdog_d   = (wdog_q & ~wmask) | (data_i & wmask);
            wd_cnt_d = wdog_d[23:0];
        end else if (wdog_q[31]) begin
            if (wd_cnt_q == 24'd0)
                wd_cnt_d = wdog_q[23:0];
            else
                wd_cnt_d = wd_cnt_q - 24'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdog_q   <= '0;
            wd_cnt_q <= '0;
        end else begin
            wdog_q   <= wdog_d;
            wd_cnt_q <= wd_cnt_d;
        end
    end

    assign wdog_rst_o = wdog_q[31] && (wd_cnt_q == 24'd0);
`else
    assign wdog_rst_o = 1'b0;
`endif

    always_comb begin
        rdata = 32'd0;
        case (off)
            OFF_CTRL:    rdata = {29'd0, ctrl_q};
            OFF_COUNT:   rdata = count_q;
            OFF_COMPARE: rdata = compare_q;
            OFF_STATUS:  rdata = {31'd0, match_q};
            OFF_PRE:     rdata = 32'(prescale_q);
`ifdef TIMER_WDOG_EN
            OFF_WDOG:    rdata = wdog_q;
`endif
            default:     rdata = 32'd0;
        endcase
        data_o = (ce && !we && hit) ? rdata : 32'd0;
    end

endmodule

// File: doc/sopc_timer.md
Name: sopc_timer

Overview:
Memory-mapped timer/interrupt responder on the openmips data bus (ce/we/addr/sel/data), sitting beside data_ram in the SOPC as a second bus slave.
- CPU programs a prescaler, a compare value and a control word.
- Block counts, flags matches and raises int_o toward the CPU interrupt input.
- Same bus timing as data_ram: reads combinational, writes on the rising clock edge.

Parameters:
BASE_ADDR, 32'h1000_0000, block base; hit when addr[31:8] == BASE_ADDR[31:8]
PRESCALE_W, 16, width of prescaler register/counter (1..32)

Ports:
clk  input  1  system clock, single clock domain
rst  input  1  reset, asynchronous, active-high
ce  input  1  bus chip enable from CPU
we  input  1  1 = write, 0 = read
addr  input  32  byte address; word offset = addr[4:2]
sel  input  4  byte enables; sel[i] enables data_i[8i+7:8i]
data_i  input  32  write data from CPU
data_o  output  32  read data to CPU
int_o  output  1  timer interrupt, level
wdog_rst_o  output  1  watchdog reset request (0 unless TIMER_WDOG_EN)

Behaviour:
- Register map (offset):
  - 0x00 CTRL: bit0 EN, bit1 AUTORELOAD, bit2 IRQ_EN; other bits read 0.
  - 0x04 COUNT: r/w.
  - 0x08 COMPARE: r/w.
  - 0x0C STATUS: bit0 MATCH, write-1-to-clear.
  - 0x10 PRESCALE: low PRESCALE_W bits r/w.
  - 0x14 WDOG (optional feature).
  - Other offsets: read 0, writes ignored.
- Write: on posedge when ce && we && hit; per-byte merge under sel. sel=0 writes nothing.
- Read: data_o = selected register when ce && !we && hit, else 32'h0. Purely combinational, zero latency.
- Reset (async): CTRL, COUNT, COMPARE, STATUS, PRESCALE, prescaler counter = 0. data_o = 0, int_o = 0, wdog_rst_o = 0.
- Prescaler:
  - pre_cnt increments each cycle while EN=1.
  - When pre_cnt == PRESCALE, assert internal tick and set pre_cnt to 0. PRESCALE=0 gives a tick every cycle.
  - EN=0 holds pre_cnt at 0.
- On tick:
  - If COUNT == COMPARE: set MATCH. COUNT <= 0 if AUTORELOAD, else COUNT+1.
  - Otherwise: COUNT <= COUNT+1, wrapping 32'hFFFF_FFFF -> 0.
- int_o = MATCH && IRQ_EN, from registered state only. Rises the cycle after the MATCH-setting edge and stays high until MATCH is cleared or IRQ_EN drops.
- Simultaneous events:
  - Bus write to COUNT and tick in the same cycle: write wins, no compare that cycle.
  - W1C to MATCH and a new match in the same cycle: set wins, MATCH stays 1.
  - Write clearing EN: pre_cnt reset to 0 at that edge; COUNT holds.
  - Write to PRESCALE mid-count: takes effect for the next comparison. If pre_cnt > new PRESCALE, pre_cnt counts up to wrap at 2^PRESCALE_W before the next tick.
- Reset asserted mid-operation clears all state immediately; outputs go to reset values without waiting for clk.

Optional Feature:
TIMER_WDOG_EN
- Defined:
  - Adds WDOG at 0x14: bit31 WD_EN, bits[23:0] WD_LOAD; reads return written value.
  - Internal 24-bit down-counter wd_cnt is loaded from WD_LOAD on any write to WDOG (kick).
  - wd_cnt decrements each clk while WD_EN=1.
  - When wd_cnt reaches 0 with WD_EN=1, wdog_rst_o pulses high for exactly 1 cycle and wd_cnt reloads from WD_LOAD.
  - Reset clears WDOG, wd_cnt and wdog_rst_o.
- Undefined: 0x14 reads 0, writes ignored, wdog_rst_o tied 0, no watchdog logic synthesized.

Test Plan:
- Reset/read: assert rst mid-cycle -> all registers read 0, int_o=0; ce=0 or addr 0x2000_0000 -> data_o=0.
- Byte writes: write 0x1000_0008 data 0xAABBCCDD sel=4'b0101 onto COMPARE=0 -> reads 0x00BB00DD.
- Compare/IRQ: PRESCALE=0, COMPARE=5, CTRL=0x7 -> MATCH set on the tick at COUNT=5; COUNT then 0; int_o high the next cycle. W1C STATUS=1 -> int_o low.
- Prescale/wrap: PRESCALE=3, COUNT=0xFFFF_FFFF, COMPARE=0x10, CTRL=0x1 -> COUNT becomes 0 after 4 cycles and increments every 4 cycles after; int_o stays 0.
- Collisions: write COUNT=0x100 on a tick cycle -> COUNT reads 0x100. W1C STATUS on a match cycle -> MATCH remains 1.
- TIMER_WDOG_EN: WDOG=0x8000_0004, no kick -> wdog_rst_o 1-cycle pulse 4 cycles later, repeats every 5 cycles. Kick each 3 cycles -> no pulse. Macro off -> wdog_rst_o constant 0.
